// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: execute/writeback bundles, FSM states and small helpers.
package memory_stage_pkg;

    typedef logic [31:0] u32;
    typedef logic [4:0]  reg_idx_t;

    typedef struct packed {
        logic     mem_to_reg;
        logic     mem_write;
        logic     reg_write;
        logic     reg_dst;
        u32       alu_result;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t rd;
        u32       pc;
        u32       pc_plus_4;
        u32       instruction;
        u32       write_data;
    } e_m_reg_t;

    typedef struct packed {
        logic     reg_write;
        logic     reg_dst;
        logic     mem_to_reg;
        u32       alu_result;
        u32       read_data;
        reg_idx_t rt;
        reg_idx_t rd;
        u32       pc;
    } m_w_reg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    function automatic logic is_mem_op(input logic mem_to_reg, input logic mem_write);
        return mem_to_reg | mem_write;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-bus request/response handshake between the MEM stage (master) and memory (slave).
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic dreq_valid;
    u32   dreq_addr;
    logic dreq_write;
    u32   dreq_wdata;
    logic dreq_addr_ok;
    logic dresp_ok;
    u32   dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_write, dreq_wdata,
        input  dreq_addr_ok, dresp_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_write, dreq_wdata,
        output dreq_addr_ok, dresp_ok, dresp_data
    );

endinterface

// File: rtl/memory_stage_mem_wait_timer.sv
// Response wait counter: cleared outside WAIT, counts while enabled, flags the last allowed cycle.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at LAST so a stalled enable can never wrap the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = (cnt_q == LAST);

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: registers the execute bundle, runs LW/SW on the data bus, emits the writeback bundle.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 256
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  e_m_reg_t             e_m_reg,
    input  logic                 e_m_valid,
    output logic                 e_m_ready,
    memory_stage_if.master       dbus,
    output m_w_reg_t             m_w_reg,
    output logic                 m_w_valid,
    output logic                 stall,
    output logic                 err_align,
    output logic                 err_timeout
);

    mem_state_t state_q, state_d;
    m_w_reg_t   mw_q, mw_d, pend_q, pend_d, wb_c;
    logic       ready_q, ready_d;
    logic       mw_valid_q, mw_valid_d;
    logic       req_valid_q, req_valid_d;
    logic       req_write_q, req_write_d;
    u32         req_addr_q, req_addr_d;
    u32         req_wdata_q, req_wdata_d;
    logic       err_align_q, err_align_d;
    logic       err_timeout_q, err_timeout_d;
    logic       accept_c, accept_mem_c, aligned_c, expired_c, finish_c;
    logic       unused_c;

    assign accept_c     = e_m_valid & ready_q;
    assign accept_mem_c = accept_c & is_mem_op(e_m_reg.mem_to_reg, e_m_reg.mem_write);
    assign aligned_c    = (e_m_reg.alu_result[1:0] == 2'b00);
    assign unused_c     = ^{e_m_reg.rs, e_m_reg.pc_plus_4, e_m_reg.instruction};

    // Writeback view of the incoming bundle; stores never write the register file.
    always_comb begin
        wb_c            = '0;
        wb_c.reg_write  = e_m_reg.reg_write & ~e_m_reg.mem_write;
        wb_c.reg_dst    = e_m_reg.reg_dst;
        wb_c.mem_to_reg = e_m_reg.mem_to_reg;
        wb_c.alu_result = e_m_reg.alu_result;
        wb_c.rt         = e_m_reg.rt;
        wb_c.rd         = e_m_reg.rd;
        wb_c.pc         = e_m_reg.pc;
    end

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (state_q != WAIT),
        .en        (state_q == WAIT),
        .expired_c (expired_c)
    );

    always_comb begin
        state_d       = state_q;
        mw_d          = mw_q;
        pend_d        = pend_q;
        mw_valid_d    = 1'b0;
        req_valid_d   = 1'b0;
        req_addr_d    = req_addr_q;
        req_write_d   = req_write_q;
        req_wdata_d   = req_wdata_q;
        err_align_d   = 1'b0;
        err_timeout_d = 1'b0;
        finish_c      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept_c) begin
                    if (!accept_mem_c) begin
                        state_d    = DONE;
                        mw_d       = wb_c;
                        mw_valid_d = 1'b1;
                    end else if (!aligned_c) begin
                        state_d        = DONE;
                        mw_d           = wb_c;
                        mw_d.reg_write = 1'b0;
                        mw_valid_d     = 1'b1;
                        err_align_d    = 1'b1;
                    end else begin
                        state_d     = REQ;
                        pend_d      = wb_c;
                        req_valid_d = 1'b1;
                        req_addr_d  = e_m_reg.alu_result;
                        req_write_d = e_m_reg.mem_write;
                        req_wdata_d = e_m_reg.write_data;
                    end
                end
            end
            REQ: begin
                req_valid_d = 1'b1;
                if (dbus.dreq_addr_ok) begin
                    req_valid_d = 1'b0;
                    if (dbus.dresp_ok) begin
                        finish_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dbus.dresp_ok) begin
                    finish_c = 1'b1;
                end else if (expired_c) begin
                    state_d        = DONE;
                    mw_d           = pend_q;
                    mw_d.reg_write = 1'b0;
                    mw_valid_d     = 1'b1;
                    err_timeout_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Response beat completes the access; only loads take the returned data.
        if (finish_c) begin
            state_d    = DONE;
            mw_d       = pend_q;
            mw_valid_d = 1'b1;
            if (!req_write_q) begin
                mw_d.read_data = dbus.dresp_data;
            end
        end

        ready_d = (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            mw_q          <= '0;
            pend_q        <= '0;
            ready_q       <= 1'b1;
            mw_valid_q    <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_write_q   <= 1'b0;
            req_wdata_q   <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mw_q          <= mw_d;
            pend_q        <= pend_d;
            ready_q       <= ready_d;
            mw_valid_q    <= mw_valid_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_write_q   <= req_write_d;
            req_wdata_q   <= req_wdata_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign e_m_ready       = ready_q;
    assign m_w_reg         = mw_q;
    assign m_w_valid       = mw_valid_q;
    assign err_align       = err_align_q;
    assign err_timeout     = err_timeout_q;
    assign dbus.dreq_valid = req_valid_q;
    assign dbus.dreq_addr  = req_addr_q;
    assign dbus.dreq_write = req_write_q;
    assign dbus.dreq_wdata = req_wdata_q;
    // Upstream must also freeze in the very cycle a memory op is taken.
    assign stall           = ~ready_q | accept_mem_c;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized ops against a transaction model.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int unsigned WAIT_MAX = 8;

    logic     clk = 1'b0;
    logic     resetn;
    e_m_reg_t e_m_reg;
    logic     e_m_valid;
    logic     e_m_ready;
    m_w_reg_t m_w_reg;
    logic     m_w_valid;
    logic     stall;
    logic     err_align;
    logic     err_timeout;

    memory_stage_if dbus ();

    memory_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .e_m_reg     (e_m_reg),
        .e_m_valid   (e_m_valid),
        .e_m_ready   (e_m_ready),
        .dbus        (dbus),
        .m_w_reg     (m_w_reg),
        .m_w_valid   (m_w_valid),
        .stall       (stall),
        .err_align   (err_align),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic e_m_reg_t mk(input logic ld, input logic st, input logic rw,
                                    input u32 addr, input u32 wd);
        e_m_reg_t b;
        b.mem_to_reg  = ld;
        b.mem_write   = st;
        b.reg_write   = rw;
        b.reg_dst     = 1'($urandom);
        b.alu_result  = addr;
        b.rs          = 5'($urandom);
        b.rt          = 5'($urandom);
        b.rd          = 5'($urandom);
        b.pc          = $urandom;
        b.pc_plus_4   = b.pc + 32'd4;
        b.instruction = $urandom;
        b.write_data  = wd;
        return b;
    endfunction

    // Expected writeback bundle from the bundle and the fate of the access.
    function automatic m_w_reg_t exp_wb(input e_m_reg_t b, input logic responded,
                                        input u32 rdata, input logic dropped);
        m_w_reg_t w;
        w            = '0;
        w.reg_write  = b.reg_write & ~b.mem_write & ~dropped;
        w.reg_dst    = b.reg_dst;
        w.mem_to_reg = b.mem_to_reg;
        w.alu_result = b.alu_result;
        w.read_data  = (b.mem_to_reg && !b.mem_write && responded) ? rdata : 32'h0;
        w.rt         = b.rt;
        w.rd         = b.rd;
        w.pc         = b.pc;
        return w;
    endfunction

    // One op end to end. a_dly: REQ cycles before addr_ok. r_dly: -1 = response with addr_ok,
    // k = response in WAIT cycle k, >= WAIT_MAX = no response within the window.
    task automatic run_op(input string name, input e_m_reg_t b, input int a_dly,
                          input int r_dly, input u32 rdata);
        int stall_n, req_n, mwv_n, lat, ea_n, et_n, bad_req, wait_idx, waitn;
        int exp_stall, exp_req, exp_lat;
        logic is_mem, aligned, timeout, dropped, responded;
        m_w_reg_t got;
        stall_n = 0; req_n = 0; mwv_n = 0; lat = -1; ea_n = 0; et_n = 0;
        bad_req = 0; wait_idx = -1; got = '0; timeout = 1'b0;

        is_mem  = b.mem_to_reg | b.mem_write;
        aligned = (b.alu_result[1:0] == 2'b00);
        if (!is_mem) begin
            exp_stall = 0; exp_req = 0; exp_lat = 1; dropped = 1'b0; responded = 1'b0;
        end else if (!aligned) begin
            exp_stall = 1; exp_req = 0; exp_lat = 1; dropped = 1'b1; responded = 1'b0;
        end else begin
            timeout   = (r_dly >= int'(WAIT_MAX));
            waitn     = (r_dly < 0) ? 0 : (timeout ? int'(WAIT_MAX) : r_dly + 1);
            exp_req   = a_dly + 1;
            exp_stall = 1 + exp_req + waitn;
            exp_lat   = exp_stall;
            dropped   = timeout;
            responded = !timeout;
        end

        check({name, ".ready"}, 128'(e_m_ready), 128'(1'b1));
        e_m_reg   = b;
        e_m_valid = 1'b1;
        for (int c = 0; c < 400 && lat < 0; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (err_align) ea_n++;
            if (err_timeout) et_n++;
            if (m_w_valid) begin
                mwv_n++;
                lat = c;
                got = m_w_reg;
            end
            if (wait_idx >= 0) begin
                if (wait_idx == r_dly) begin
                    dbus.dresp_ok   = 1'b1;
                    dbus.dresp_data = rdata;
                end
                wait_idx++;
            end
            if (dbus.dreq_valid) begin
                req_n++;
                if (dbus.dreq_addr !== b.alu_result || dbus.dreq_write !== b.mem_write ||
                    (b.mem_write && dbus.dreq_wdata !== b.write_data))
                    bad_req++;
                if (req_n - 1 == a_dly) begin
                    dbus.dreq_addr_ok = 1'b1;
                    if (r_dly < 0) begin
                        dbus.dresp_ok   = 1'b1;
                        dbus.dresp_data = rdata;
                    end else begin
                        wait_idx = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
            e_m_valid         = 1'b0;
            dbus.dreq_addr_ok = 1'b0;
            dbus.dresp_ok     = 1'b0;
            dbus.dresp_data   = $urandom;
        end

        check({name, ".stall_cycles"}, 128'(stall_n), 128'(exp_stall));
        check({name, ".req_cycles"},   128'(req_n),   128'(exp_req));
        check({name, ".req_fields"},   128'(bad_req), 128'(0));
        check({name, ".latency"},      128'(lat),     128'(exp_lat));
        check({name, ".mw_valid_n"},   128'(mwv_n),   128'(1));
        check({name, ".err_align"},    128'(ea_n),    128'((is_mem && !aligned) ? 1 : 0));
        check({name, ".err_timeout"},  128'(et_n),    128'(timeout ? 1 : 0));
        check({name, ".m_w_reg"},      128'(got),     128'(exp_wb(b, responded, rdata, dropped)));
    endtask

    initial begin
        e_m_reg_t b, b2;
        int kind, a_dly, r_dly;
        u32 addr;

        resetn            = 1'b0;
        e_m_valid         = 1'b0;
        e_m_reg           = '0;
        dbus.dreq_addr_ok = 1'b0;
        dbus.dresp_ok     = 1'b0;
        dbus.dresp_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.m_w_valid",  128'(m_w_valid),       128'(0));
        check("reset.dreq_valid", 128'(dbus.dreq_valid), 128'(0));
        check("reset.stall",      128'(stall),           128'(0));
        check("reset.errs",       128'({err_align, err_timeout}), 128'(0));
        check("reset.m_w_reg",    128'(m_w_reg),         128'(0));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        b = mk(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        b.rd = 5'd5;
        run_op("addi", b, 0, 0, 32'h0);

        run_op("lw", mk(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0), 0, 1, 32'hDEAD_BEEF);
        run_op("sw", mk(1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h1234_5678), 0, -1, 32'hFFFF_FFFF);
        run_op("lw_misaligned", mk(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0), 0, 0, 32'h0);
        run_op("lw_timeout", mk(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0), 1, int'(WAIT_MAX), 32'hBAD0_BAD0);
        run_op("after_timeout", mk(1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0), 0, 0, 32'h0);

        // Back-to-back ALU ops at one per cycle.
        b  = mk(1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 32'h0);
        b2 = mk(1'b0, 1'b0, 1'b1, 32'h5A5A_0002, 32'h0);
        e_m_reg = b; e_m_valid = 1'b1;
        @(negedge clk);
        check("b2b.stall0", 128'(stall), 128'(0));
        @(posedge clk); #1;
        e_m_reg = b2;
        @(negedge clk);
        check("b2b.valid1", 128'(m_w_valid), 128'(1));
        check("b2b.wb1",    128'(m_w_reg),   128'(exp_wb(b, 1'b0, 32'h0, 1'b0)));
        check("b2b.ready1", 128'({e_m_ready, stall}), 128'(2'b10));
        @(posedge clk); #1;
        e_m_valid = 1'b0;
        @(negedge clk);
        check("b2b.valid2", 128'(m_w_valid), 128'(1));
        check("b2b.wb2",    128'(m_w_reg),   128'(exp_wb(b2, 1'b0, 32'h0, 1'b0)));
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b.bubble", 128'(m_w_valid), 128'(0));
        @(posedge clk); #1;

        // Reset asserted while the load sits in WAIT.
        e_m_reg = mk(1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0); e_m_valid = 1'b1;
        @(posedge clk); #1;
        e_m_valid = 1'b0;
        @(negedge clk);
        dbus.dreq_addr_ok = 1'b1;
        @(posedge clk); #1;
        dbus.dreq_addr_ok = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_wait.dreq_valid", 128'(dbus.dreq_valid), 128'(0));
        check("rst_wait.m_w_valid",  128'(m_w_valid),       128'(0));
        check("rst_wait.stall",      128'(stall),           128'(0));
        check("rst_wait.errs",       128'({err_align, err_timeout}), 128'(0));
        check("rst_wait.m_w_reg",    128'(m_w_reg),         128'(0));
        dbus.dresp_ok   = 1'b1;
        dbus.dresp_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dbus.dresp_ok = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_wait.no_resp", 128'(m_w_valid), 128'(0));
        @(posedge clk); #1;
        run_op("addi_after_rst", mk(1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0), 0, 0, 32'h0);

        // Randomized mix of ALU, load, store and misaligned ops.
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 3));
            addr  = $urandom & 32'hFFFF_FFFC;
            a_dly = int'($urandom_range(0, 3));
            r_dly = ($urandom_range(0, 9) == 0) ? int'(WAIT_MAX) + 1 : int'($urandom_range(0, 5)) - 1;
            case (kind)
                0: b = mk(1'b0, 1'b0, 1'($urandom), $urandom, 32'h0);
                1: b = mk(1'b1, 1'b0, 1'b1, addr, $urandom);
                2: b = mk(1'b0, 1'b1, 1'b0, addr, $urandom);
                default: b = mk(1'($urandom), 1'b1, 1'b1, addr | 32'(2'($urandom_range(1, 3))), $urandom);
            endcase
            run_op($sformatf("rand%0d", i), b, a_dly, r_dly, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
